mem_arbiter: RTL and testbench

//  Shares one word-wide memory port among NUM_REQ matcher-style requesters (one per pipeline proc).

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port among NUM_REQ requesters.
// A grant is locked until the winner drops ce; a sticky watchdog flags over-long holds.
module mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 1024,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_ce_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*4-1:0]      req_width_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [3:0]                mem_width_o,
  output logic [DATA_W-1:0]         mem_data_o,
  input  logic [DATA_W-1:0]         mem_data_i,
  input  logic                      mem_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic               timeout_reg;

  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [HOLD_W-1:0]  hold_cnt_next;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg[i]) gidx = IDX_W'(i);
    end
  end

  // Rotating priority: search upward starting just after the last winner.
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(ptr_reg) + k) % NUM_REQ;
      if (!pick_found && req_ce_i[c]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(c);
      end
    end
  end

  assign hold_cnt_next = (hold_cnt_reg == HOLD_W'(MAX_HOLD)) ? hold_cnt_reg : hold_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      ptr_reg      <= IDX_W'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg    <= NUM_REQ'(1) << pick_idx;
            ptr_reg      <= pick_idx;
            hold_cnt_reg <= '0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          hold_cnt_reg <= hold_cnt_next;
          if (hold_cnt_next == HOLD_W'(MAX_HOLD)) timeout_reg <= 1'b1;
          if (!req_ce_i[gidx]) begin
            grant_reg <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  // The port is driven only while BUSY, so ce drops in the very cycle the winner releases.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    req_ready_o = '0;
    req_data_o  = '0;
    if (state_reg == BUSY) begin
      mem_ce_o          = req_ce_i[gidx];
      mem_we_o          = req_we_i[gidx];
      mem_addr_o        = req_addr_i[gidx*ADDR_W +: ADDR_W];
      mem_width_o       = req_width_i[gidx*4 +: 4];
      mem_data_o        = req_data_i[gidx*DATA_W +: DATA_W];
      req_ready_o[gidx] = mem_ready_i;
      req_data_o        = mem_data_i;
    end
  end

  assign grant_o   = grant_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single grant, priority rotation, isolation, watchdog, reset abort.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ce, we;
  logic [N*AW-1:0] addr;
  logic [N*4-1:0]  width;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] req_data;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_width;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [N-1:0]  grant;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .MAX_HOLD(8), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(ce), .req_we_i(we), .req_addr_i(addr), .req_width_i(width), .req_data_i(wdata),
    .req_ready_o(req_ready), .req_data_o(req_data),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_width_o(mem_width),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ready_i(mem_ready),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: 1 time unit after the rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    ce  = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, ngr;
    int exp_order [5];
    logic [N-1:0] prev_g;
    bit dropped;

    rst = 1'b1; ce = '0; we = '0; addr = '0; width = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #2;
    check("rst_grant", grant, 4'b0000);
    check("rst_mem_ce", mem_ce, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_timeout", timeout, 1'b0);

    // 1: single requester 2
    cyc();
    ce = 4'b0100; addr[2*AW +: AW] = 32'h100; width[2*4 +: 4] = 4'd4; wdata[2*DW +: DW] = 32'h5555_0002;
    #2;
    check("t1_grant_t", grant, 4'b0000);
    check("t1_mem_ce_t", mem_ce, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      mem_ready = 1'b1; mem_rdata = 32'hA0 + k;
      #2;
      check("t1_grant", grant, 4'b0100);
      check("t1_mem_ce", mem_ce, 1'b1);
      check("t1_addr", mem_addr, 32'h100);
      check("t1_width", mem_width, 4'd4);
      check("t1_ready_hi", req_ready, 4'b0100);
      check("t1_rdata", req_data, 32'hA0 + k);
      cyc();
      mem_ready = 1'b0;
      #2;
      check("t1_ready_lo", req_ready, 4'b0000);
    end
    cyc();
    ce = 4'b0000;
    #2;
    check("t1_release_ce", mem_ce, 1'b0);
    cyc();
    mem_ready = 1'b1;
    #2;
    check("t1_idle_grant", grant, 4'b0000);
    check("t1_idle_ready", req_ready, 4'b0000);
    check("t1_idle_addr", mem_addr, 32'h0);
    check("t1_timeout", timeout, 1'b0);
    mem_ready = 1'b0;

    // 2: requesters 0 and 3 together after reset
    do_reset();
    ce = 4'b1001;
    cyc(); #2;
    check("t2_first", grant, 4'b0001);
    cyc(); #2;
    check("t2_hold", grant, 4'b0001);
    cyc();
    ce = 4'b1000;
    #2;
    check("t2_drop_ce", mem_ce, 1'b0);
    cyc(); #2;
    check("t2_gap", grant, 4'b0000);
    cyc(); #2;
    check("t2_second", grant, 4'b1000);
    check("t2_second_ce", mem_ce, 1'b1);
    cyc(); ce = 4'b0000;
    cyc();

    // 3: all requesters, 5-cycle transactions
    do_reset();
    ce = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
    cnt = 0; ngr = 0; prev_g = '0; dropped = 1'b0;
    for (int c = 0; c < 100 && ngr < 5; c++) begin
      cyc();
      if (dropped) check("t3_idle_gap", grant, 4'b0000);
      if (grant != '0 && prev_g == '0) begin
        check("t3_order", grant, 64'(1) << exp_order[ngr]);
        ngr++;
        cnt = 0;
      end
      dropped = 1'b0;
      if (grant != '0 && cnt == 4) begin
        ce = 4'b1111 & ~grant;
        dropped = 1'b1;
      end else begin
        ce = 4'b1111;
        if (grant != '0) cnt++;
      end
      #2;
      check("t3_mem_ce", mem_ce, (grant != '0) && !dropped);
      prev_g = grant;
    end
    check("t3_done", ngr, 5);
    cyc(); ce = 4'b0000;
    cyc();

    // 4: requester 1 granted, requester 2 ignored
    cyc();
    ce = 4'b0010; addr[1*AW +: AW] = 32'h40; wdata[1*DW +: DW] = 32'hDEAD_0001;
    we = 4'b0010; width[1*4 +: 4] = 4'd2;
    cyc();
    ce = 4'b0110; addr[2*AW +: AW] = 32'hFFC; mem_ready = 1'b1; mem_rdata = 32'h1234;
    #2;
    check("t4_grant", grant, 4'b0010);
    check("t4_addr", mem_addr, 32'h40);
    check("t4_we", mem_we, 1'b1);
    check("t4_width", mem_width, 4'd2);
    check("t4_wdata", mem_wdata, 32'hDEAD_0001);
    check("t4_ready", req_ready, 4'b0010);
    check("t4_rdata", req_data, 32'h1234);
    cyc(); mem_ready = 1'b0; #2;
    check("t4_ready_lo", req_ready, 4'b0000);
    cyc(); mem_ready = 1'b1; #2;
    check("t4_ready2_lo", req_ready[2], 1'b0);
    check("t4_addr2", mem_addr, 32'h40);
    cyc();
    ce = 4'b0100; mem_ready = 1'b0;
    #2;
    check("t4_release", mem_ce, 1'b0);
    cyc(); #2;
    check("t4_gap", grant, 4'b0000);
    check("t4_gap_addr", mem_addr, 32'h0);
    cyc(); #2;
    check("t4_next", grant, 4'b0100);
    check("t4_next_addr", mem_addr, 32'hFFC);
    cyc(); ce = 4'b0000;
    cyc();

    // 5: watchdog with MAX_HOLD=8
    do_reset();
    ce = 4'b0001;
    for (int b = 1; b <= 20; b++) begin
      cyc(); #2;
      if (b == 7) check("t5_no_timeout", timeout, 1'b0);
      if (b == 9) check("t5_timeout", timeout, 1'b1);
      if (b == 20) begin
        check("t5_timeout_held", timeout, 1'b1);
        check("t5_grant_kept", grant, 4'b0001);
      end
    end
    cyc();
    ce = 4'b0000;
    #2;
    check("t5_release_ce", mem_ce, 1'b0);
    cyc(); #2;
    check("t5_idle", grant, 4'b0000);
    check("t5_sticky", timeout, 1'b1);

    // 6: reset mid-BUSY
    cyc(); ce = 4'b0010;
    cyc(); #2;
    check("t6_grant", grant, 4'b0010);
    cyc();
    cyc(); rst = 1'b1;
    cyc();
    rst = 1'b0; ce = 4'b0110; mem_ready = 1'b1;
    #2;
    check("t6_rst_grant", grant, 4'b0000);
    check("t6_rst_ce", mem_ce, 1'b0);
    check("t6_rst_timeout", timeout, 1'b0);
    check("t6_rst_ready", req_ready, 4'b0000);
    cyc(); #2;
    check("t6_fresh", grant, 4'b0010);
    cyc(); ce = 4'b0000; mem_ready = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
